async_count_checker: RTL and testbench

//   Reads the 4-bit ripple (asynchronous) counter output into the clk_100MHz domain.

---
 rtl/async_count_pkg.sv | 23 ++
 rtl/count_sync_filter.sv | 56 +++++
 rtl/async_count_checker.sv | 117 +++++++++++
 tb/tb_async_count_checker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_count_pkg.sv
// Shared types and defaults for the ripple-counter checker and its sync filter.
package async_count_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH          = 4;
    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_STABLE_CYCLES  = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 200_000_000;
    localparam int unsigned DEF_ERR_W          = 8;

    // val + 1 wrapped to the low 'width' bits.
    function automatic logic [31:0] next_count(input logic [31:0] val, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/count_sync_filter.sv
// Multi-flop synchroniser followed by a stability filter for an asynchronous bus.
// cand is the last synced value; stable_hit is high once cand has been seen
// unchanged for STABLE_CYCLES consecutive synced samples.
module count_sync_filter
    import async_count_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cand,
    output logic             stable_hit
);

    localparam int unsigned     SW         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0]   STABLE_MAX = SW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [SW-1:0]    stable;

    // Synchroniser chain; only the last stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Candidate register and saturating stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= '0;
            stable <= '0;
        end else if (synced != cand) begin
            cand   <= synced;
            stable <= '0;
        end else if (stable != STABLE_MAX) begin
            stable <= stable + SW'(1);
        end
    end

    assign stable_hit = (stable == STABLE_MAX);

endmodule

// File: rtl/async_count_checker.sv
// Consumer and self-check for a ripple counter: synchronises and filters the
// raw bits, then checks every accepted value is the previous one plus one,
// flagging sequence errors and stalls with a saturating error tally.
module async_count_checker
    import async_count_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned ERR_W          = DEF_ERR_W
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] q_async,
    output logic [WIDTH-1:0] count_q,
    output logic             count_valid,
    output logic             step_err,
    output logic             stall_err,
    output logic [ERR_W-1:0] err_count,
    output logic             tracking
);

    // Timer saturates one past the firing value so the stall pulse cannot repeat.
    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_HOLD = TW'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cand;
    logic             stable_hit;
    logic             accept;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] expected_next;
    logic [TW-1:0]    timer;
    logic [ERR_W-1:0] err_reg;

    count_sync_filter #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk_100MHz),
        .rst        (rst),
        .din        (q_async),
        .cand       (cand),
        .stable_hit (stable_hit)
    );

    assign expected_next = WIDTH'(next_count(32'(count_reg), WIDTH));

    // FSM state register.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enable low always returns to IDLE.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ACQUIRE;
                ACQUIRE: if (accept) state_next = TRACK;
                TRACK:   state_next = TRACK;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs: accept event, pulses and the visible count value.
    always_comb begin
        accept = 1'b0;
        case (state)
            ACQUIRE: accept = enable && stable_hit;
            TRACK:   accept = enable && stable_hit && (cand != count_reg);
            default: accept = 1'b0;
        endcase
        tracking    = (state == TRACK);
        count_valid = accept;
        step_err    = accept && (state == TRACK) && (cand != expected_next);
        // An accept in the same cycle as the timeout suppresses the stall.
        stall_err   = enable && (state == TRACK) && !accept && (timer == TO_LAST);
        count_q     = accept ? cand : count_reg;
    end

    // Accepted value, stall timer and saturating error counter.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            timer     <= '0;
            err_reg   <= '0;
        end else begin
            if (accept) begin
                count_reg <= cand;
            end
            if (!enable || (state != TRACK) || accept) begin
                timer <= '0;
            end else if (timer != TO_HOLD) begin
                timer <= timer + TW'(1);
            end
            if ((step_err || stall_err) && (err_reg != '1)) begin
                err_reg <= err_reg + ERR_W'(1);
            end
        end
    end

    assign err_count = err_reg;

endmodule

// File: tb/tb_async_count_checker.sv
// Bench for async_count_checker: table of directed segments, hand-written
// corner sequences and random stimulus, all against a per-cycle reference model.
`timescale 1ns/1ps
module tb_async_count_checker;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned STABLE  = 4;
    localparam int unsigned TIMEOUT = 1000;
    localparam int unsigned ERR_W   = 8;
    localparam int          MOD     = 1 << WIDTH;

    logic             clk_100MHz = 1'b0;
    logic             rst        = 1'b1;
    logic             enable     = 1'b0;
    logic [WIDTH-1:0] q_async    = '0;
    logic [WIDTH-1:0] count_q;
    logic             count_valid;
    logic             step_err;
    logic             stall_err;
    logic [ERR_W-1:0] err_count;
    logic             tracking;

    int checks = 0;
    int errors = 0;
    int obs_valid = 0;
    int obs_step  = 0;
    int obs_stall = 0;

    logic [WIDTH-1:0] q_e   = '0;
    logic             en_e  = 1'b0;
    logic             rst_e = 1'b1;

    typedef struct {
        logic       en;
        logic [3:0] q;
        int         hold;
        int         valids;
        int         steps;
        int         stalls;
        int         cq;
        int         err;
    } vec_t;

    vec_t vecs[$];

    async_count_checker #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERR_W          (ERR_W)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst         (rst),
        .enable      (enable),
        .q_async     (q_async),
        .count_q     (count_q),
        .count_valid (count_valid),
        .step_err    (step_err),
        .stall_err   (stall_err),
        .err_count   (err_count),
        .tracking    (tracking)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Inputs as seen by the DUT at each rising edge.
    always @(posedge clk_100MHz) begin
        q_e   <= q_async;
        en_e  <= enable;
        rst_e <= rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic en, input int q, input int hold, input int v,
                                input int s, input int t, input int cq, input int err);
        vec_t r;
        r.en = en; r.q = 4'(q); r.hold = hold; r.valids = v;
        r.steps = s; r.stalls = t; r.cq = cq; r.err = err;
        vecs.push_back(r);
    endfunction

    // Reference: run-length of the delayed sample stream decides acceptance;
    // mode 0/1/2 = idle/acquire/track; quiet = track cycles since last accept.
    task automatic scoreboard();
        int  mode, last, err, quiet, run_val, run_len, x, cand_m, exp_cq, prev_cand;
        bit  prev_acc, prev_err, acc, serr, terr, hit, trk;
        int  dly[$];
        mode = 0; last = 0; err = 0; quiet = 0; run_val = 0; run_len = 1;
        prev_cand = 0; prev_acc = 0; prev_err = 0;
        for (int i = 0; i < SYNC; i++) dly.push_back(0);
        forever begin
            @(negedge clk_100MHz);
            if (rst || rst_e) begin
                mode = 0; last = 0; err = 0; quiet = 0; run_val = 0; run_len = 1;
                dly.delete();
                for (int i = 0; i < SYNC; i++) dly.push_back(0);
            end else begin
                if (prev_acc) last = prev_cand;
                if (prev_err && err < (1 << ERR_W) - 1) err++;
                if (!en_e) mode = 0;
                else if (mode == 0) mode = 1;
                else if (mode == 1 && prev_acc) mode = 2;
                dly.push_back(int'(q_e));
                x = dly.pop_front();
                if (x == run_val) begin
                    if (run_len < STABLE) run_len++;
                end else begin
                    run_val = x;
                    run_len = 1;
                end
            end
            hit    = (run_len >= STABLE);
            cand_m = run_val;
            acc    = enable && hit && ((mode == 1) || (mode == 2 && cand_m != last));
            serr   = acc && (mode == 2) && (cand_m != (last + 1) % MOD);
            terr   = enable && (mode == 2) && !acc && (quiet + 1 == TIMEOUT);
            if (!enable || mode != 2 || acc) quiet = 0;
            else quiet++;
            exp_cq = acc ? cand_m : last;
            trk    = (mode == 2);
            checks++;
            if (count_q !== 4'(exp_cq) || count_valid !== acc || step_err !== serr ||
                stall_err !== terr || err_count !== 8'(err) || tracking !== trk) begin
                errors++;
                $display("FAIL cycle_model t=%0t actual cq=%0d v=%0b se=%0b st=%0b ec=%0d tr=%0b required cq=%0d v=%0b se=%0b st=%0b ec=%0d tr=%0b",
                         $time, count_q, count_valid, step_err, stall_err, err_count, tracking,
                         exp_cq, acc, serr, terr, err, trk);
            end
            if (count_valid === 1'b1) obs_valid++;
            if (step_err === 1'b1)    obs_step++;
            if (stall_err === 1'b1)   obs_stall++;
            prev_acc  = acc;
            prev_err  = serr || terr;
            prev_cand = cand_m;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_v, b_s, b_t, lat;
        bit found;

        fork
            scoreboard();
        join_none

        // Segments: enable, q, hold, valids, step_errs, stall_errs, final count_q, final err_count.
        add(0, 3, 20, 0, 0, 0, 0, 0);
        add(1, 3, 50, 1, 0, 0, 3, 0);
        for (int v = 4; v <= 16; v++) add(1, v % 16, 50, 1, 0, 0, v % 16, 0);
        add(0, 7, 10, 0, 0, 0, 0, 0);
        add(1, 7, 50, 1, 0, 0, 7, 0);
        add(1, 6, 1, 0, 0, 0, 7, 0);
        add(1, 4, 1, 0, 0, 0, 7, 0);
        add(1, 0, 1, 0, 0, 0, 7, 0);
        add(1, 8, 50, 1, 0, 0, 8, 0);
        add(1, 9, 2, 0, 0, 0, 8, 0);
        add(1, 8, 50, 0, 0, 0, 8, 0);
        add(0, 2, 10, 0, 0, 0, 8, 0);
        add(1, 2, 50, 1, 0, 0, 2, 0);
        add(1, 5, 50, 1, 1, 0, 5, 1);
        add(1, 6, 50, 1, 0, 0, 6, 1);
        add(1, 6, 1100, 0, 0, 1, 6, 2);
        add(1, 7, 50, 1, 0, 0, 7, 2);
        add(1, 7, 1100, 0, 0, 1, 7, 3);
        add(0, 7, 5, 0, 0, 0, 7, 3);
        add(0, 12, 20, 0, 0, 0, 7, 3);
        add(1, 12, 50, 1, 0, 0, 12, 3);

        // Reset state, held for 100 ns.
        #3;
        chk("reset_count_q", int'(count_q), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_tracking", int'(tracking), 0);
        #99;
        rst = 1'b0;
        @(posedge clk_100MHz);
        #2;

        foreach (vecs[i]) begin
            b_v = obs_valid; b_s = obs_step; b_t = obs_stall;
            enable  = vecs[i].en;
            q_async = vecs[i].q;
            repeat (vecs[i].hold) @(posedge clk_100MHz);
            #2;
            chk($sformatf("vec%0d_valids", i), obs_valid - b_v, vecs[i].valids);
            chk($sformatf("vec%0d_step_errs", i), obs_step - b_s, vecs[i].steps);
            chk($sformatf("vec%0d_stall_errs", i), obs_stall - b_t, vecs[i].stalls);
            chk($sformatf("vec%0d_count_q", i), int'(count_q), vecs[i].cq);
            chk($sformatf("vec%0d_err_count", i), int'(err_count), vecs[i].err);
        end

        // Latency from a settled input change to count_valid.
        q_async = 4'd13;
        lat = 0;
        found = 0;
        for (int k = 1; k <= 30 && !found; k++) begin
            @(negedge clk_100MHz);
            if (count_valid === 1'b1) begin
                lat = k;
                found = 1;
                chk("latency_count_q", int'(count_q), 13);
            end
        end
        chk("latency_cycles", lat, 7);
        repeat (10) @(posedge clk_100MHz);
        #2;

        // Dropping enable leaves TRACK next cycle and holds count_q.
        enable = 1'b0;
        @(posedge clk_100MHz);
        #2;
        chk("drop_tracking", int'(tracking), 0);
        chk("drop_count_q", int'(count_q), 13);
        q_async = 4'd2;
        repeat (10) @(posedge clk_100MHz);
        #2;
        enable = 1'b1;
        repeat (20) @(posedge clk_100MHz);
        #2;
        chk("reacquire_count_q", int'(count_q), 2);
        chk("reacquire_err_count", int'(err_count), 3);
        chk("reacquire_tracking", int'(tracking), 1);

        // Random segments: mostly increments, some jumps, short glitchy holds, rare long freezes.
        for (int s = 0; s < 250; s++) begin
            int r;
            int hold;
            r = $urandom_range(0, 99);
            if (r < 4) enable = ~enable;
            if (r < 60) q_async = q_async + 4'd1;
            else if (r < 80) q_async = 4'($urandom_range(0, 15));
            hold = (r >= 97) ? $urandom_range(990, 1010) : $urandom_range(1, 12);
            repeat (hold) @(posedge clk_100MHz);
            #2;
        end

        // Asynchronous reset in TRACK with count_q = 5.
        enable = 1'b0;
        q_async = 4'd5;
        repeat (20) @(posedge clk_100MHz);
        #2;
        enable = 1'b1;
        repeat (50) @(posedge clk_100MHz);
        #2;
        chk("pre_reset_count_q", int'(count_q), 5);
        chk("pre_reset_tracking", int'(tracking), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_count_q", int'(count_q), 0);
        chk("async_reset_valid", int'(count_valid), 0);
        chk("async_reset_step_err", int'(step_err), 0);
        chk("async_reset_stall_err", int'(stall_err), 0);
        chk("async_reset_err_count", int'(err_count), 0);
        chk("async_reset_tracking", int'(tracking), 0);
        @(posedge clk_100MHz);
        #2;
        rst = 1'b0;
        repeat (20) @(posedge clk_100MHz);
        #2;
        chk("post_reset_count_q", int'(count_q), 5);
        chk("post_reset_err_count", int'(err_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
